// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider:
// FSM state encoding, default operand width, divide-by-zero quotient.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUO = '1;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift {rem, quo} left, trial-subtract the
// divisor, keep the difference and set the quotient bit when it is non-negative.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem stays below the divisor, so WIDTH+1 bits hold the shifted value and the sign of the difference
    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor};

    always_comb begin
        quo_next = {quo[WIDTH-2:0], ~diff[WIDTH]};
        rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    end

endmodule

// File: rtl/div.sv
// Iterative 32-cycle restoring divider for MIPS DIV/DIVU with a sel/ready
// handshake; div_result = {remainder, quotient}.
module div
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   div_A,
    input  logic [WIDTH-1:0]   div_B,
    input  logic               div_signed,
    input  logic               div_sel,
    input  logic               div_cancel,
    output logic [2*WIDTH-1:0] div_result,
    output logic               div_ready
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    div_state_t state, state_next;
    logic start, step, finish;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] rem_q, quo_q, b_q;
    logic [WIDTH-1:0] rem_step, quo_step;
    logic [WIDTH-1:0] rem_fix, quo_fix;
    logic             sign_q, sign_r, zero_div;
    logic [CW-1:0]    count;

    assign a_neg = div_signed & div_A[WIDTH-1];
    assign b_neg = div_signed & div_B[WIDTH-1];
    assign a_mag = a_neg ? -div_A : div_A;
    assign b_mag = b_neg ? -div_B : div_B;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (b_q),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Cancel, or EX dropping its request, wins over both start and completion
    always_comb begin
        state_next = state;
        start      = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (div_sel && !div_cancel) begin
                    start      = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (div_cancel || !div_sel) begin
                    state_next = IDLE;
                end else begin
                    step = 1'b1;
                    if (count == LAST_STEP) state_next = FIX;
                end
            end
            FIX: begin
                state_next = IDLE;
                if (!div_cancel && div_sel) finish = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q    <= '0;
            quo_q    <= '0;
            b_q      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            zero_div <= 1'b0;
            count    <= '0;
        end else if (start) begin
            rem_q    <= '0;
            quo_q    <= a_mag;
            b_q      <= b_mag;
            sign_q   <= a_neg ^ b_neg;
            sign_r   <= a_neg;
            zero_div <= (div_B == '0);
            count    <= '0;
        end else if (step) begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            count <= count + 1'b1;
        end
    end

    // With a zero divisor rem ends as |A|, so the remainder negation restores the raw dividend
    assign quo_fix = zero_div ? {WIDTH{DIV_ZERO_QUO[0]}} : (sign_q ? -quo_q : quo_q);
    assign rem_fix = sign_r ? -rem_q : rem_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_ready  <= 1'b0;
            div_result <= '0;
        end else begin
            div_ready <= finish;
            if (finish) div_result <= {rem_fix, quo_fix};
        end
    end

endmodule

// File: tb/tb_div.sv
// Directed, table-driven bench for the restoring divider: results, latency,
// ready pulse width, cancel/drop-sel aborts and asynchronous reset.
module tb_div;
    import div_pkg::*;

    localparam int W = DIV_WIDTH;
    localparam int LATENCY = 33;
    localparam int NVEC = 12;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   div_A, div_B;
    logic           div_signed, div_sel, div_cancel;
    logic [2*W-1:0] div_result;
    logic           div_ready;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           sgn;
        logic [2*W-1:0] expected;
        string          name;
    } vec_t;

    vec_t vecs[NVEC];

    div #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_A      (div_A),
        .div_B      (div_B),
        .div_signed (div_signed),
        .div_sel    (div_sel),
        .div_cancel (div_cancel),
        .div_result (div_result),
        .div_ready  (div_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [2*W-1:0] actual,
                               input logic [2*W-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Counts edges after the start edge until div_ready is seen, bounded
    task automatic waitReady(output int edges);
        bit seen = 1'b0;
        edges = 0;
        while (!seen && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            if (div_ready) seen = 1'b1;
        end
    endtask

    task automatic watchNoReady(input int cycles, output int pulses);
        pulses = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (div_ready) pulses++;
        end
    endtask

    // Operands are scrambled after the start edge to show they are only sampled once
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sgn, output int edges);
        div_A      = a;
        div_B      = b;
        div_signed = sgn;
        div_sel    = 1'b1;
        @(posedge clk);
        #1;
        div_A      = $urandom;
        div_B      = $urandom;
        div_signed = ~sgn;
        waitReady(edges);
        div_sel = 1'b0;
    endtask

    initial begin
        int edges;
        int pulses;
        logic [2*W-1:0] prev;

        vecs[0]  = '{32'd100,        32'd7,        1'b0, 64'h00000002_0000000E, "divu_100_7"};
        vecs[1]  = '{32'hFFFFFFF9,   32'd2,        1'b1, 64'hFFFFFFFF_FFFFFFFD, "div_m7_2"};
        vecs[2]  = '{32'd7,          32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, "div_7_m2"};
        vecs[3]  = '{32'h80000000,   32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, "div_overflow"};
        vecs[4]  = '{32'h80000000,   32'hFFFFFFFF, 1'b0, 64'h80000000_00000000, "divu_big"};
        vecs[5]  = '{32'h12345678,   32'd0,        1'b0, 64'h12345678_FFFFFFFF, "divu_by_zero"};
        vecs[6]  = '{32'h12345678,   32'd0,        1'b1, 64'h12345678_FFFFFFFF, "div_by_zero"};
        vecs[7]  = '{32'hFFFFFFFF,   32'd1,        1'b0, 64'h00000000_FFFFFFFF, "divu_max_1"};
        vecs[8]  = '{32'hFFFFFF9C,   32'hFFFFFFF9, 1'b1, 64'hFFFFFFFE_0000000E, "div_m100_m7"};
        vecs[9]  = '{32'h80000000,   32'd0,        1'b1, 64'h80000000_FFFFFFFF, "div_min_by_zero"};
        vecs[10] = '{32'hFFFFFFFB,   32'd0,        1'b1, 64'hFFFFFFFB_FFFFFFFF, "div_m5_by_zero"};
        vecs[11] = '{32'd0,          32'd5,        1'b0, 64'h00000000_00000000, "divu_0_5"};

        rst        = 1'b0;
        div_A      = '0;
        div_B      = '0;
        div_signed = 1'b0;
        div_sel    = 1'b0;
        div_cancel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ready", {63'd0, div_ready}, 64'd0);
        checkOutput("reset_result", div_result, 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sgn, edges);
            checkOutput({vecs[i].name, "_result"}, div_result, vecs[i].expected);
            checkOutput({vecs[i].name, "_latency"}, 64'(edges), 64'(LATENCY));
            @(posedge clk);
            #1;
            checkOutput({vecs[i].name, "_pulse"}, {63'd0, div_ready}, 64'd0);
            checkOutput({vecs[i].name, "_hold"}, div_result, vecs[i].expected);
        end

        // Cancel pulsed at E10
        prev       = vecs[NVEC-1].expected;
        div_A      = 32'd1000;
        div_B      = 32'd3;
        div_signed = 1'b0;
        div_sel    = 1'b1;
        @(posedge clk);
        #1;
        repeat (9) @(posedge clk);
        #1;
        div_cancel = 1'b1;
        @(posedge clk);
        #1;
        div_cancel = 1'b0;
        div_sel    = 1'b0;
        watchNoReady(40, pulses);
        checkOutput("cancel_no_ready", 64'(pulses), 64'd0);
        checkOutput("cancel_result_kept", div_result, prev);

        applyStimulus(32'd9, 32'd3, 1'b0, edges);
        checkOutput("after_cancel_result", div_result, 64'h00000000_00000003);
        checkOutput("after_cancel_latency", 64'(edges), 64'(LATENCY));

        // div_sel dropped at E20
        @(posedge clk);
        #1;
        div_A   = 32'd1000;
        div_B   = 32'd3;
        div_sel = 1'b1;
        @(posedge clk);
        #1;
        repeat (19) @(posedge clk);
        #1;
        div_sel = 1'b0;
        watchNoReady(40, pulses);
        checkOutput("dropsel_no_ready", 64'(pulses), 64'd0);
        checkOutput("dropsel_result_kept", div_result, 64'h00000000_00000003);

        // Asynchronous reset between edges mid-BUSY, then restart with div_sel held
        div_A   = 32'd50;
        div_B   = 32'd6;
        div_sel = 1'b1;
        @(posedge clk);
        #1;
        repeat (15) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("async_reset_ready", {63'd0, div_ready}, 64'd0);
        checkOutput("async_reset_result", div_result, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        waitReady(edges);
        div_sel = 1'b0;
        checkOutput("post_reset_result", div_result, 64'h00000002_00000008);
        checkOutput("post_reset_latency", 64'(edges), 64'(LATENCY));
        @(posedge clk);
        #1;
        checkOutput("post_reset_pulse", {63'd0, div_ready}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/div.md
Name: div

Overview:
- Iterative 32-cycle radix-2 restoring divider for the EX stage; the counterpart of the multiplier for MIPS DIV/DIVU.
- Uses the same sel/ready handshake as the multiplier: EX raises `div_sel` and stalls until `div_ready` pulses.
- Result format: `div_result` = {remainder, quotient}; the upper half writes HI, the lower half writes LO.

Parameters:
WIDTH, 32, operand width; the iteration counter is $clog2(WIDTH)+1 bits.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
div_A  in  WIDTH  dividend
div_B  in  WIDTH  divisor
div_signed  in  1  1 = DIV (two's complement), 0 = DIVU
div_sel  in  1  request; held high by EX while the divide is pending
div_cancel  in  1  flush (exception or branch kill); aborts any operation
div_result  out  2*WIDTH  {remainder, quotient}; registered, holds until the next completion
div_ready  out  1  one-cycle pulse; `div_result` is valid for this divide

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, div_ready=0, div_result=0, counter=0, all internal registers 0.
- States: IDLE, BUSY, FIX.
- IDLE:
  - div_sel=1 and div_cancel=0 at edge E0: latch |A| and |B| (absolute values when div_signed=1, raw values otherwise).
  - Also latch sign_q = A[msb]^B[msb], sign_r = A[msb] (both 0 when unsigned), and a zero-divisor flag.
  - Clear the partial remainder and counter; go to BUSY.
- BUSY, edges E1..E32, one iteration per edge:
  - Shift {rem, quo} left by 1.
  - Trial subtract rem - |B| with a WIDTH+1-bit difference.
  - If non-negative: keep the difference and set quo[0]=1.
  - Counter increments; at the edge where the counter reaches WIDTH, go to FIX.
- FIX, edge E33:
  - quotient = sign_q ? -quo : quo.
  - remainder = sign_r ? -rem : rem.
  - Register into div_result, set div_ready=1, go to IDLE.
- Next edge (E34): div_ready<=0. Latency from the start edge to the ready rising edge is exactly 33 edges, independent of operand values. There is no early termination.
- Divide by zero: iterations still run and the sign fixup is bypassed. Result is quotient = all ones, remainder = dividend (raw div_A), for both signed and unsigned.
- Overflow 0x80000000 / 0xFFFFFFFF (signed): quotient 0x80000000, remainder 0. This falls out of the unsigned-magnitude path; no special case.
- Abort:
  - div_cancel=1 in any state → IDLE on the next edge, div_ready=0, div_result unchanged.
  - div_sel=0 while in BUSY/FIX is treated the same as a cancel.
  - Cancel has priority over start and completion.
- Operands are sampled only at E0; changes on div_A/div_B/div_signed during BUSY are ignored.
- Re-issue: if div_sel is still high in IDLE after the ready pulse, a new divide starts. The requester must drop div_sel in the cycle div_ready is seen, or accept the restart. This matches the multiplier contract.
- div_ready is never high in two consecutive cycles.

Decomposition:
- Shared package: state encoding localparams (IDLE/BUSY/FIX), the WIDTH default, and the divide-by-zero quotient constant (all ones).
- One natural sub-module, div_step: combinational single iteration. Inputs rem, quo, |B|; outputs next rem, next quo.
- The rest (sign handling, counter, FSM, output registers) stays in div.

Test Plan:
- DIVU 100 / 7 → div_result = {0x00000002, 0x0000000E}; div_ready high for exactly one cycle, 33 edges after the start edge.
- DIV 0xFFFFFFF9 (-7) / 2 → quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). DIV 7 / 0xFFFFFFFE → quotient 0xFFFFFFFD, remainder 0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. DIVU same operands → quotient 0, remainder 0x80000000.
- Divide by zero: 0x12345678 / 0 with div_signed=0 and with div_signed=1 → quotient 0xFFFFFFFF, remainder 0x12345678, normal 33-edge latency.
- div_cancel pulsed at E10 → no ready pulse, div_result keeps its previous value. Then DIVU 9 / 3 → {0, 3} with full 33-edge latency. Also drop div_sel at E20 → same abort behaviour.
- rst asserted asynchronously mid-BUSY (between edges) → div_ready=0 and div_result=0 immediately. After release, with div_sel held high: new start, correct result.
